// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// The two requesters, the FIFOs and the top-level sequencer all see
// the same request layout and state encoding from here.
package regfile_pkg;

   localparam int DW     = 22;
   localparam int AW     = 4;
   localparam int NREG   = 11;
   localparam int FDEPTH = 2;
   localparam int CW     = 3;

   // r11 is sourced from outside the file and cannot be written.
   // Any address at or above it is illegal.
   localparam logic [AW-1:0] REG_R11 = 4'd11;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_req_t;

   typedef enum logic {
      INIT,
      RUN
   } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO that buffers one requester's writeback requests.
// The head entry is always visible, so the arbiter can look at it
// before it decides whether to pop it.
// The caller only pushes when the FIFO is not full and only pops when
// it is not empty. Both can happen on the same edge.
module wb_fifo
   import regfile_pkg::wb_req_t;
#(
   parameter int FDEPTH = 2
)
(
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  wb_req_t push_data,
   input  logic    pop,
   output wb_req_t head,
   output logic    full,
   output logic    empty
);

   localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

   wb_req_t       mem [FDEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;

   assign full  = (count == (PW+1)'(FDEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Storage is left unreset. An entry only becomes visible after it
   // has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // The pointers wrap naturally because the depth is a power of two.
   // The occupancy count tracks the net effect of push and pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Catches a caller that breaks the full/empty handshake.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && full && !pop));
         assert (!(pop && empty));
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the single write port of the 11 x 22-bit register file.
// After reset it walks a zero into every writable register.
// After that it queues ALU (A) and load (M) writebacks in one FIFO per
// requester. Each cycle it grants one FIFO head, round-robin, into a
// registered write port.
// It also keeps a small counter per register of writes that have been
// accepted but not yet retired. Decode can stall on RAW hazards from the
// resulting mask.
module regfile_wb_arbiter
   import regfile_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [AW-1:0]   a_addr,
   input  logic [DW-1:0]   a_data,
   input  logic            m_valid,
   output logic            m_ready,
   input  logic [AW-1:0]   m_addr,
   input  logic [DW-1:0]   m_data,
   output logic            rf_we,
   output logic [AW-1:0]   rf_wa,
   output logic [DW-1:0]   rf_wd,
   output logic [NREG-1:0] pend_mask,
   output logic            init_done,
   output logic            addr_err
);

   localparam logic [AW-1:0] LAST_REG = REG_R11 - AW'(1);
   localparam logic [CW:0]   CNT_ONE  = (CW+1)'(1);
   localparam logic [CW:0]   CNT_MAX  = (CW+1)'(2 * FDEPTH + 1);

   wb_state_e     state;
   logic [AW-1:0] init_cnt;
   logic          last_grant_m;
   logic          rf_tracked;

   wb_req_t a_req;
   wb_req_t m_req;
   wb_req_t a_head;
   wb_req_t m_head;
   logic    a_full;
   logic    a_empty;
   logic    m_full;
   logic    m_empty;

   logic a_acc;
   logic m_acc;
   logic a_legal;
   logic m_legal;
   logic a_pop;
   logic m_pop;

   logic [CW-1:0] cnt      [NREG];
   logic [CW:0]   cnt_next [NREG];

   // Requesters are only accepted in RUN and never while reset is held.
   // Ready depends only on occupancy before any pop, so a full FIFO
   // stays unready even in a cycle where its head is being popped.
   assign a_ready = !rst && (state == RUN) && !a_full;
   assign m_ready = !rst && (state == RUN) && !m_full;

   assign a_acc   = a_valid && a_ready;
   assign m_acc   = m_valid && m_ready;
   assign a_legal = a_acc && (a_addr < REG_R11);
   assign m_legal = m_acc && (m_addr < REG_R11);

   assign a_req = '{addr: a_addr, data: a_data};
   assign m_req = '{addr: m_addr, data: m_data};

   // Round-robin grant. A lone valid head always wins. When both heads
   // are valid, the requester that was not granted last time wins.
   assign a_pop = (state == RUN) && !a_empty && (m_empty || last_grant_m);
   assign m_pop = (state == RUN) && !m_empty && (a_empty || !last_grant_m);

   wb_fifo #(.FDEPTH(FDEPTH)) u_a_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (a_legal),
      .push_data (a_req),
      .pop       (a_pop),
      .head      (a_head),
      .full      (a_full),
      .empty     (a_empty)
   );

   wb_fifo #(.FDEPTH(FDEPTH)) u_m_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (m_legal),
      .push_data (m_req),
      .pop       (m_pop),
      .head      (m_head),
      .full      (m_full),
      .empty     (m_empty)
   );

   // Sequencer: INIT walks zeros into r0..r10, then RUN loads the granted
   // head into the write-port register. rf_tracked marks a loaded entry
   // that came from a FIFO, so that its retirement releases a pending
   // count. Clear-walk writes were never counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= INIT;
         init_cnt     <= '0;
         last_grant_m <= 1'b1;
         rf_we        <= 1'b0;
         rf_wa        <= '0;
         rf_wd        <= '0;
         rf_tracked   <= 1'b0;
         init_done    <= 1'b0;
         addr_err     <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               rf_we      <= 1'b1;
               rf_wa      <= init_cnt;
               rf_wd      <= '0;
               rf_tracked <= 1'b0;
               init_cnt   <= init_cnt + AW'(1);
               if (init_cnt == LAST_REG) begin
                  state     <= RUN;
                  init_done <= 1'b1;
               end
            end
            RUN: begin
               if (a_pop) begin
                  rf_we        <= 1'b1;
                  rf_wa        <= a_head.addr;
                  rf_wd        <= a_head.data;
                  rf_tracked   <= 1'b1;
                  last_grant_m <= 1'b0;
               end else if (m_pop) begin
                  rf_we        <= 1'b1;
                  rf_wa        <= m_head.addr;
                  rf_wd        <= m_head.data;
                  rf_tracked   <= 1'b1;
                  last_grant_m <= 1'b1;
               end else begin
                  rf_we      <= 1'b0;
                  rf_tracked <= 1'b0;
               end
               if ((a_acc && !a_legal) || (m_acc && !m_legal)) begin
                  addr_err <= 1'b1;
               end
            end
            default: begin
               state <= INIT;
            end
         endcase
      end
   end

   // Next pending count per register. A legal accept adds one for each
   // requester that targets the register. The write-port entry that
   // retires at this edge subtracts one. The extra bit exposes overflow
   // and underflow to the check below.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         cnt_next[i] = {1'b0, cnt[i]};
         if (a_legal && (a_addr == AW'(i))) begin
            cnt_next[i] = cnt_next[i] + CNT_ONE;
         end
         if (m_legal && (m_addr == AW'(i))) begin
            cnt_next[i] = cnt_next[i] + CNT_ONE;
         end
         if (rf_tracked && (rf_wa == AW'(i))) begin
            cnt_next[i] = cnt_next[i] - CNT_ONE;
         end
      end
   end

   // Pending counters are cleared by reset, which also discards
   // everything that was queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt[i] <= cnt_next[i][CW-1:0];
         end
      end
   end

   // Two full FIFOs plus the write-port entry bound every count.
   // Exceeding that bound, or going below zero, means bookkeeping is broken.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            assert (cnt_next[i] <= CNT_MAX);
         end
      end
   end

   // A register is hazardous while any accepted write to it is unretired.
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < NREG; i++) begin
         pend_mask[i] = (cnt[i] != '0);
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter.
// The reference model keeps one queue per requester, a last-grant flag
// and the current write-port entry. The expected pending mask is every
// register named by a queued entry or by the write-port entry.
module tb_regfile_wb_arbiter;

   localparam int NR = 11;
   localparam int FD = 2;

   logic        clk;
   logic        rst;
   logic        a_valid;
   logic        a_ready;
   logic [3:0]  a_addr;
   logic [21:0] a_data;
   logic        m_valid;
   logic        m_ready;
   logic [3:0]  m_addr;
   logic [21:0] m_data;
   logic        rf_we;
   logic [3:0]  rf_wa;
   logic [21:0] rf_wd;
   logic [10:0] pend_mask;
   logic        init_done;
   logic        addr_err;

   regfile_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_addr    (m_addr),
      .m_data    (m_data),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd),
      .pend_mask (pend_mask),
      .init_done (init_done),
      .addr_err  (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  addr;
      logic [21:0] data;
   } req_t;

   req_t        qa[$];
   req_t        qm[$];
   bit          last_m;
   bit          exp_we;
   logic [3:0]  exp_wa;
   logic [21:0] exp_wd;
   logic [10:0] exp_pend;
   bit          exp_err;
   bit          exp_a_ready;
   bit          exp_m_ready;
   logic        obs_a_ready;
   logic        obs_m_ready;

   int checks;
   int passes;

   // Model state right after a completed clear walk.
   task automatic model_after_init();
      qa.delete();
      qm.delete();
      last_m   = 1'b1;
      exp_we   = 1'b0;
      exp_wa   = 4'd10;
      exp_wd   = '0;
      exp_pend = '0;
      exp_err  = 1'b0;
   endtask

   // Drives one RUN cycle, samples ready before the edge, and advances the model.
   task automatic run_cycle(input bit av, input logic [3:0] aa, input logic [21:0] ad,
                            input bit mv, input logic [3:0] ma, input logic [21:0] md);
      req_t cur;
      a_valid = av; a_addr = aa; a_data = ad;
      m_valid = mv; m_addr = ma; m_data = md;
      exp_a_ready = (qa.size() < FD);
      exp_m_ready = (qm.size() < FD);
      #1;
      obs_a_ready = a_ready;
      obs_m_ready = m_ready;
      @(posedge clk);
      if (qa.size() != 0 && (qm.size() == 0 || last_m)) begin
         cur = qa.pop_front();
         exp_we = 1'b1; exp_wa = cur.addr; exp_wd = cur.data; last_m = 1'b0;
      end else if (qm.size() != 0) begin
         cur = qm.pop_front();
         exp_we = 1'b1; exp_wa = cur.addr; exp_wd = cur.data; last_m = 1'b1;
      end else begin
         exp_we = 1'b0;
      end
      if (av && exp_a_ready) begin
         if (aa < 4'd11) begin cur.addr = aa; cur.data = ad; qa.push_back(cur); end
         else exp_err = 1'b1;
      end
      if (mv && exp_m_ready) begin
         if (ma < 4'd11) begin cur.addr = ma; cur.data = md; qm.push_back(cur); end
         else exp_err = 1'b1;
      end
      exp_pend = '0;
      foreach (qa[i]) exp_pend[qa[i].addr] = 1'b1;
      foreach (qm[i]) exp_pend[qm[i].addr] = 1'b1;
      if (exp_we) exp_pend[exp_wa] = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_valid = 1'b1; a_addr = 4'd0; a_data = '0;
      m_valid = 1'b1; m_addr = 4'd0; m_data = '0;
      #1;
      checks++;
      if ({a_ready, m_ready} !== 2'b00)
         $display("[TB] FAIL reset_ready: got %b%b want 00", a_ready, m_ready);
      else passes++;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({rf_we, rf_wa, rf_wd} !== '0)
         $display("[TB] FAIL reset_port: got we=%b wa=%0d wd=%h want 0/0/0", rf_we, rf_wa, rf_wd);
      else passes++;
      checks++;
      if ({init_done, addr_err, pend_mask} !== '0)
         $display("[TB] FAIL reset_flags: got done=%b err=%b pend=%b want all 0", init_done, addr_err, pend_mask);
      else passes++;
      a_valid = 1'b0; m_valid = 1'b0;
      rst = 1'b0;
   endtask

   // Expects 11 clear writes r0..r10, then the first idle RUN cycle.
   task automatic test_init_walk();
      for (int i = 0; i < NR; i++) begin
         checks++;
         if ({a_ready, m_ready} !== 2'b00)
            $display("[TB] FAIL init_ready[%0d]: got %b%b want 00", i, a_ready, m_ready);
         else passes++;
         @(posedge clk);
         #1;
         checks++;
         if (rf_we !== 1'b1 || rf_wa !== 4'(i) || rf_wd !== '0 || pend_mask !== '0)
            $display("[TB] FAIL init_walk[%0d]: got we=%b wa=%0d wd=%h pend=%b want 1/%0d/0/0",
                     i, rf_we, rf_wa, rf_wd, pend_mask, i);
         else passes++;
         checks++;
         if (init_done !== (i == NR - 1))
            $display("[TB] FAIL init_done[%0d]: got %b want %b", i, init_done, (i == NR - 1));
         else passes++;
      end
      model_after_init();
      run_cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (rf_we !== 1'b0 || obs_a_ready !== 1'b1 || obs_m_ready !== 1'b1)
         $display("[TB] FAIL init_end: got we=%b ready=%b%b want we=0 ready=11", rf_we, obs_a_ready, obs_m_ready);
      else passes++;
   endtask

   task automatic test_single_write();
      int pend_cycles;
      bit seen_write;
      run_cycle(1, 4'd3, 22'h2A5A5, 0, 0, 0);
      pend_cycles = pend_mask[3] ? 1 : 0;
      seen_write  = 1'b0;
      checks++;
      if (rf_we !== 1'b0 || pend_mask !== 11'b000_0000_1000)
         $display("[TB] FAIL single_accept: got we=%b pend=%b want we=0 pend=00000001000", rf_we, pend_mask);
      else passes++;
      for (int c = 0; c < 4; c++) begin
         run_cycle(0, 0, 0, 0, 0, 0);
         if (pend_mask[3]) pend_cycles++;
         if (c == 0 && rf_we === 1'b1 && rf_wa === 4'd3 && rf_wd === 22'h2A5A5) seen_write = 1'b1;
         checks++;
         if (rf_we !== exp_we || rf_wa !== exp_wa || rf_wd !== exp_wd || pend_mask !== exp_pend)
            $display("[TB] FAIL single_port[%0d]: got we=%b wa=%0d wd=%h pend=%b want %b/%0d/%h/%b",
                     c, rf_we, rf_wa, rf_wd, pend_mask, exp_we, exp_wa, exp_wd, exp_pend);
         else passes++;
      end
      checks++;
      if (!seen_write)
         $display("[TB] FAIL single_latency: write r3=2A5A5 not seen one cycle after accept, got we=%b", 1'b0);
      else passes++;
      checks++;
      if (pend_cycles != 2)
         $display("[TB] FAIL single_pend_cycles: got %0d want 2", pend_cycles);
      else passes++;
   endtask

   // Both requesters assert valid every cycle. Grants must alternate and both FIFOs must fill.
   task automatic test_contention();
      int  grants;
      int  repeats;
      bit  prev_m;
      bit  have_prev;
      bit  saw_a_full;
      bit  saw_m_full;
      grants = 0; repeats = 0; have_prev = 0; saw_a_full = 0; saw_m_full = 0; prev_m = 0;
      for (int c = 0; c < 10; c++) begin
         run_cycle(1, 4'd1, 22'd1, 1, 4'd2, 22'd2);
         if (obs_a_ready === 1'b0) saw_a_full = 1'b1;
         if (obs_m_ready === 1'b0) saw_m_full = 1'b1;
         checks++;
         if (obs_a_ready !== exp_a_ready || obs_m_ready !== exp_m_ready)
            $display("[TB] FAIL cont_ready[%0d]: got %b%b want %b%b", c, obs_a_ready, obs_m_ready, exp_a_ready, exp_m_ready);
         else passes++;
         checks++;
         if (rf_we !== exp_we || rf_wa !== exp_wa || rf_wd !== exp_wd || pend_mask !== exp_pend)
            $display("[TB] FAIL cont_port[%0d]: got we=%b wa=%0d wd=%h pend=%b want %b/%0d/%h/%b",
                     c, rf_we, rf_wa, rf_wd, pend_mask, exp_we, exp_wa, exp_wd, exp_pend);
         else passes++;
         if (rf_we === 1'b1) begin
            grants++;
            if (have_prev && prev_m == (rf_wa == 4'd2)) repeats++;
            prev_m = (rf_wa == 4'd2);
            have_prev = 1'b1;
         end
      end
      checks++;
      if (repeats != 0 || grants < 8)
         $display("[TB] FAIL cont_alternate: got grants=%0d repeats=%0d want >=8 and 0", grants, repeats);
      else passes++;
      checks++;
      if (!(saw_a_full && saw_m_full))
         $display("[TB] FAIL cont_full: got a_unready=%b m_unready=%b want 1/1", saw_a_full, saw_m_full);
      else passes++;
      for (int c = 0; c < 8; c++) run_cycle(0, 0, 0, 0, 0, 0);
      checks++;
      if (pend_mask !== '0 || rf_we !== 1'b0)
         $display("[TB] FAIL cont_drain: got pend=%b we=%b want 0/0", pend_mask, rf_we);
      else passes++;
   endtask

   task automatic test_same_register();
      int pend_cycles;
      int writes;
      run_cycle(1, 4'd5, 22'h11111, 1, 4'd5, 22'h22222);
      pend_cycles = pend_mask[5] ? 1 : 0;
      writes = 0;
      for (int c = 0; c < 4; c++) begin
         run_cycle(0, 0, 0, 0, 0, 0);
         if (pend_mask[5]) pend_cycles++;
         if (rf_we === 1'b1 && rf_wa === 4'd5) writes++;
         checks++;
         if (rf_we !== exp_we || rf_wa !== exp_wa || rf_wd !== exp_wd || pend_mask !== exp_pend)
            $display("[TB] FAIL same_port[%0d]: got we=%b wa=%0d wd=%h pend=%b want %b/%0d/%h/%b",
                     c, rf_we, rf_wa, rf_wd, pend_mask, exp_we, exp_wa, exp_wd, exp_pend);
         else passes++;
      end
      checks++;
      if (pend_cycles != 3 || writes != 2)
         $display("[TB] FAIL same_reg: got pend_cycles=%0d writes=%0d want 3 and 2", pend_cycles, writes);
      else passes++;
   endtask

   task automatic test_illegal_addr();
      checks++;
      if (addr_err !== 1'b0)
         $display("[TB] FAIL illegal_pre: got addr_err=%b want 0", addr_err);
      else passes++;
      run_cycle(0, 0, 0, 1, 4'd11, 22'h3ABCD);
      run_cycle(0, 0, 0, 1, 4'd15, 22'h01234);
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (rf_we !== 1'b0 || pend_mask !== '0 || addr_err !== 1'b1)
            $display("[TB] FAIL illegal[%0d]: got we=%b pend=%b err=%b want 0/0/1", c, rf_we, pend_mask, addr_err);
         else passes++;
         run_cycle(0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic test_random();
      logic [3:0] aa;
      logic [3:0] ma;
      for (int c = 0; c < 400; c++) begin
         aa = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
         ma = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
         run_cycle(1'($urandom_range(0, 1)), aa, 22'($urandom),
                   1'($urandom_range(0, 1)), ma, 22'($urandom));
         checks++;
         if (obs_a_ready !== exp_a_ready || obs_m_ready !== exp_m_ready)
            $display("[TB] FAIL rand_ready[%0d]: got %b%b want %b%b", c, obs_a_ready, obs_m_ready, exp_a_ready, exp_m_ready);
         else passes++;
         checks++;
         if (rf_we !== exp_we || rf_wa !== exp_wa || rf_wd !== exp_wd)
            $display("[TB] FAIL rand_port[%0d]: got we=%b wa=%0d wd=%h want %b/%0d/%h",
                     c, rf_we, rf_wa, rf_wd, exp_we, exp_wa, exp_wd);
         else passes++;
         checks++;
         if (pend_mask !== exp_pend || addr_err !== exp_err || init_done !== 1'b1)
            $display("[TB] FAIL rand_flags[%0d]: got pend=%b err=%b done=%b want %b/%b/1",
                     c, pend_mask, addr_err, init_done, exp_pend, exp_err);
         else passes++;
      end
   endtask

   // Resets while writes are still queued. None of them may reach the port afterwards.
   task automatic test_mid_reset();
      for (int n = 0; n < 10 && (qa.size() + qm.size()) < 3; n++)
         run_cycle(1, 4'($urandom_range(0, 10)), 22'($urandom), 1, 4'($urandom_range(0, 10)), 22'($urandom));
      checks++;
      if ((qa.size() + qm.size()) < 3 || pend_mask === '0)
         $display("[TB] FAIL mid_fill: got queued=%0d pend=%b want >=3 and nonzero", qa.size() + qm.size(), pend_mask);
      else passes++;
      rst = 1'b1;
      #1;
      checks++;
      if ({a_ready, m_ready} !== 2'b00)
         $display("[TB] FAIL mid_ready: got %b%b want 00", a_ready, m_ready);
      else passes++;
      @(posedge clk);
      #1;
      checks++;
      if (rf_we !== 1'b0 || pend_mask !== '0 || addr_err !== 1'b0 || init_done !== 1'b0)
         $display("[TB] FAIL mid_reset: got we=%b pend=%b err=%b done=%b want 0/0/0/0", rf_we, pend_mask, addr_err, init_done);
      else passes++;
      a_valid = 1'b0; m_valid = 1'b0;
      rst = 1'b0;
      test_init_walk();
      for (int c = 0; c < 4; c++) begin
         run_cycle(0, 0, 0, 0, 0, 0);
         checks++;
         if (rf_we !== 1'b0 || pend_mask !== '0)
            $display("[TB] FAIL mid_stale[%0d]: got we=%b wa=%0d pend=%b want we=0 pend=0", c, rf_we, rf_wa, pend_mask);
         else passes++;
      end
   endtask

   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_init_walk();
      test_single_write();
      test_contention();
      test_same_register();
      test_illegal_addr();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
